cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4, number of cycles the PC stays frozen after a stop so the pipeline empties; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run_req  input  1  one-cycle request to start from IDLE or resume from HALTED.
REQ-005 step_req  input  1  one-cycle request to execute one instruction fetch, then halt.
REQ-006 stop_req  input  1  one-cycle request to halt a running CPU.
REQ-007 start_adr_in  input  [31:2]  boot address, sampled in IDLE on run_req or step_req.
REQ-008 pc  input  [31:2]  current PC from the PC stage.
REQ-009 stall  input  1  pipeline stall; when high, the PC does not advance.
REQ-010 brk_en, brk_adr  input  1, [31:2]  breakpoint enable and breakpoint address.
REQ-011 cpu_start  output  1  one-cycle pulse that loads cpu_start_adr into the PC.
REQ-012 cpu_start_adr  output  [31:2]  latched boot address.
REQ-013 cpu_stat_pc  output  1  PC advance enable.
REQ-014 running, halted  output  1, 1  status flags.
REQ-015 halt_pc  output  [31:2]  PC captured on entry to HALTED.
REQ-016 halt_cause  output  [1:0]  halt reason: 0 = none, 1 = stop, 2 = step, 3 = breakpoint.

Function
REQ-017 The block SHALL implement the states IDLE, START, RUN, STEP, DRAIN and HALTED.
REQ-018 In IDLE, run_req or step_req SHALL latch start_adr_in into cpu_start_adr, record a step flag equal to step_req, and go to START; stop_req SHALL be ignored.
REQ-019 START SHALL last exactly one cycle with cpu_start=1, cpu_stat_pc=0; the next state SHALL be STEP if the step flag is set, else RUN.
REQ-020 In RUN, cpu_stat_pc SHALL equal ~stall and running SHALL be 1.
REQ-021 In RUN, stop_req SHALL cause DRAIN next cycle with cause 1; cpu_stat_pc SHALL be 0 from the cycle after stop_req.
REQ-022 In RUN, brk_en=1 and pc==brk_adr (full 30-bit compare) and stall=0 SHALL cause DRAIN with cause 3, and cpu_stat_pc SHALL be 0 in that same cycle (combinational), so the PC does not leave brk_adr.
REQ-023 When stop_req and a breakpoint hit occur in the same cycle, cause 3 SHALL win and the REQ-022 timing SHALL apply.
REQ-024 In STEP, cpu_stat_pc SHALL equal ~stall; the first cycle with stall=0 SHALL advance the PC once and go to DRAIN with cause 2.
REQ-025 While stall=1, the block SHALL remain in STEP.
REQ-026 Breakpoints SHALL NOT be checked in STEP.
REQ-027 stop_req in STEP SHALL go to DRAIN with cause 1, with no PC advance in that cycle.
REQ-028 In DRAIN, cpu_stat_pc SHALL be 0.
REQ-029 A 4-bit down-counter loaded with DRAIN_CYCLES-1 on entry to DRAIN SHALL go to HALTED when it reaches 0, so DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-030 All requests SHALL be ignored in START and DRAIN.
REQ-031 On entry to HALTED, halt_pc SHALL capture pc and halt_cause SHALL update.
REQ-032 In HALTED, halted SHALL be 1 and cpu_stat_pc SHALL be 0.
REQ-033 In HALTED, run_req SHALL go to RUN without a cpu_start pulse, resuming at the current PC.
REQ-034 In HALTED, step_req SHALL go to STEP.
REQ-035 In HALTED, stop_req SHALL be ignored.
REQ-036 If run_req and step_req are both asserted in IDLE or HALTED, step_req SHALL win.
REQ-037 On resume from a breakpoint halt, the breakpoint SHALL be masked until pc!=brk_adr, so that run_req does not re-halt immediately.
REQ-038 Status outputs running, halted, halt_pc and halt_cause SHALL be registered; cpu_stat_pc SHALL be combinational from state, stall and breakpoint match.

Reset
REQ-039 While rst=1, the state SHALL be IDLE and all outputs SHALL be 0, including cpu_start_adr, halt_pc, halt_cause, the drain counter and the breakpoint mask.
REQ-040 Reset asserted mid-RUN or mid-DRAIN SHALL return to IDLE immediately (asynchronously) and discard any pending step flag.
REQ-041 After rst deasserts, the first run_req SHALL behave per REQ-018.

Verification
REQ-042 Start: rst, then run_req with start_adr_in=30'h100 -> cpu_start=1 for one cycle with cpu_start_adr=30'h100, then running=1 and cpu_stat_pc=1.
REQ-043 Stop: stop_req in RUN, DRAIN_CYCLES=4 -> cpu_stat_pc=0 from the next cycle; halted=1 exactly 5 cycles after stop_req; halt_cause=1; halt_pc=pc.
REQ-044 Breakpoint: brk_en=1, brk_adr=30'h104, PC counting from 30'h100 -> cpu_stat_pc=0 at pc=30'h104; halt_pc=30'h104; cause=3; a following run_req resumes without re-halting.
REQ-045 Step with stall: step_req from HALTED while stall=1 for 3 cycles -> exactly one cpu_stat_pc=1 cycle, in the first unstalled cycle; then cause=2.
REQ-046 Simultaneous events: stop_req together with a breakpoint hit -> cause 3; run_req together with step_req in IDLE -> START followed by STEP.
REQ-047 Reset during DRAIN -> IDLE immediately with all outputs 0; the next run_req produces a cpu_start pulse.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for the CPU: sequences boot, free-running, single-step,
// breakpoint and stop requests, and drains the pipeline before reporting HALTED.
module cpu_run_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        stop_req,
  input  logic [31:2] start_adr_in,
  input  logic [31:2] pc,
  input  logic        stall,
  input  logic        brk_en,
  input  logic [31:2] brk_adr,
  output logic        cpu_start,
  output logic [31:2] cpu_start_adr,
  output logic        cpu_stat_pc,
  output logic        running,
  output logic        halted,
  output logic [31:2] halt_pc,
  output logic [1:0]  halt_cause
);

  typedef enum logic [2:0] {StIdle, StStart, StRun, StStep, StDrain, StHalted} state_e;

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic        step_flag_q, step_flag_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        brk_mask_q, brk_mask_d;
  logic [31:2] start_adr_q, start_adr_d;
  logic        brk_hit;

  // Mask keeps a resumed CPU from re-halting on the breakpoint it is parked on.
  assign brk_hit       = brk_en && (pc == brk_adr) && !stall && !brk_mask_q;
  assign cpu_start_adr = start_adr_q;

  always_comb begin
    state_d     = state_q;
    step_flag_d = step_flag_q;
    drain_cnt_d = drain_cnt_q;
    cause_d     = cause_q;
    brk_mask_d  = brk_mask_q;
    start_adr_d = start_adr_q;
    cpu_start   = 1'b0;
    cpu_stat_pc = 1'b0;

    if (brk_mask_q && (pc != brk_adr)) begin
      brk_mask_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (run_req || step_req) begin
          start_adr_d = start_adr_in;
          step_flag_d = step_req;
          state_d     = StStart;
        end
      end
      StStart: begin
        cpu_start   = 1'b1;
        step_flag_d = 1'b0;
        state_d     = step_flag_q ? StStep : StRun;
      end
      StRun: begin
        cpu_stat_pc = !stall && !brk_hit;
        if (brk_hit) begin
          state_d     = StDrain;
          cause_d     = 2'd3;
          drain_cnt_d = DrainLoad;
          brk_mask_d  = 1'b1;
        end else if (stop_req) begin
          state_d     = StDrain;
          cause_d     = 2'd1;
          drain_cnt_d = DrainLoad;
        end
      end
      StStep: begin
        cpu_stat_pc = !stall && !stop_req;
        if (stop_req) begin
          state_d     = StDrain;
          cause_d     = 2'd1;
          drain_cnt_d = DrainLoad;
        end else if (!stall) begin
          state_d     = StDrain;
          cause_d     = 2'd2;
          drain_cnt_d = DrainLoad;
        end
      end
      StDrain: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      StHalted: begin
        if (step_req) begin
          state_d = StStep;
        end else if (run_req) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      step_flag_q <= 1'b0;
      drain_cnt_q <= 4'd0;
      cause_q     <= 2'd0;
      brk_mask_q  <= 1'b0;
      start_adr_q <= '0;
      running     <= 1'b0;
      halted      <= 1'b0;
      halt_pc     <= '0;
      halt_cause  <= 2'd0;
    end else begin
      state_q     <= state_d;
      step_flag_q <= step_flag_d;
      drain_cnt_q <= drain_cnt_d;
      cause_q     <= cause_d;
      brk_mask_q  <= brk_mask_d;
      start_adr_q <= start_adr_d;
      running     <= (state_d == StRun);
      halted      <= (state_d == StHalted);
      if ((state_d == StHalted) && (state_q != StHalted)) begin
        halt_pc    <= pc;
        halt_cause <= cause_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a simple PC stage model drives pc, boot and halt
// events are checked by a scoreboard monitor, cycle timing by inline checks.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, step_req, stop_req;
  logic [31:2] start_adr_in;
  logic [31:2] pc;
  logic        stall;
  logic        brk_en;
  logic [31:2] brk_adr;
  logic        cpu_start;
  logic [31:2] cpu_start_adr;
  logic        cpu_stat_pc;
  logic        running, halted;
  logic [31:2] halt_pc;
  logic [1:0]  halt_cause;

  int total = 0;
  int bad   = 0;
  int adv;
  logic        halted_prev;
  logic [29:0] start_q[$];
  logic [31:0] halt_q[$];

  cpu_run_ctrl #(.DRAIN_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .run_req      (run_req),
    .step_req     (step_req),
    .stop_req     (stop_req),
    .start_adr_in (start_adr_in),
    .pc           (pc),
    .stall        (stall),
    .brk_en       (brk_en),
    .brk_adr      (brk_adr),
    .cpu_start    (cpu_start),
    .cpu_start_adr(cpu_start_adr),
    .cpu_stat_pc  (cpu_stat_pc),
    .running      (running),
    .halted       (halted),
    .halt_pc      (halt_pc),
    .halt_cause   (halt_cause)
  );

  always #5 clk = ~clk;

  // PC stage model: load on cpu_start, otherwise advance when enabled.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (cpu_start) pc <= cpu_start_adr;
    else if (cpu_stat_pc) pc <= pc + 30'd1;
  end

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: boot pulses and halt entries pop their expected values.
  initial begin
    logic [29:0] e_adr;
    logic [31:0] e_halt;
    halted_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (cpu_start) begin
          if (start_q.size() == 0) check("start_unexpected", cpu_start, 0);
          else begin
            e_adr = start_q.pop_front();
            check("start_adr", cpu_start_adr, e_adr);
          end
        end
        if (halted && !halted_prev) begin
          if (halt_q.size() == 0) check("halt_unexpected", halted, 0);
          else begin
            e_halt = halt_q.pop_front();
            check("halt_pc_cause", {halt_pc, halt_cause}, e_halt);
          end
        end
      end
      halted_prev = halted;
    end
  end

  // Four DRAIN cycles with the PC frozen, then HALTED on the fifth.
  task automatic drain_check(input string nm);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      run_req  = 1'b0;
      step_req = 1'b0;
      stop_req = 1'b0;
      #1;
      if (k < 5) check({nm, "_drain"}, {halted, cpu_stat_pc}, 0);
      else check({nm, "_halted"}, halted, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
    stall = 1'b0; brk_en = 1'b0; brk_adr = '0; start_adr_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", {cpu_start, cpu_start_adr, cpu_stat_pc, running, halted, halt_pc,
                         halt_cause}, 0);
    @(negedge clk); rst = 1'b0;

    // Boot at 0x100, run three cycles, stop (PC advances once more to 0x103).
    @(negedge clk); run_req = 1'b1; start_adr_in = 30'h100; start_q.push_back(30'h100);
    @(negedge clk); run_req = 1'b0; #1;
    check("start_pulse", cpu_start, 1);
    check("start_no_adv", cpu_stat_pc, 0);
    @(negedge clk); #1;
    check("run_flags", {cpu_start, running, cpu_stat_pc}, 3'b011);
    @(negedge clk);
    @(negedge clk); stop_req = 1'b1; halt_q.push_back({30'h103, 2'd1}); #1;
    check("stop_cycle_adv", cpu_stat_pc, 1);
    drain_check("stop");

    // Resume without a boot pulse; breakpoint at 0x104 freezes the PC there.
    brk_en = 1'b1; brk_adr = 30'h104;
    @(negedge clk); run_req = 1'b1; #1;
    check("halted_no_adv", cpu_stat_pc, 0);
    @(negedge clk); run_req = 1'b0; #1;
    check("resume_run", {cpu_start, running, cpu_stat_pc}, 3'b011);
    @(negedge clk); halt_q.push_back({30'h104, 2'd3}); #1;
    check("brk_freeze", cpu_stat_pc, 0);
    drain_check("brk");

    // Resume while parked on the breakpoint: must not re-halt.
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0; #1;
    check("brk_masked", {running, cpu_stat_pc}, 2'b11);
    @(negedge clk); brk_adr = 30'h108; #1;
    check("past_brk", {running, halted, cpu_stat_pc}, 3'b101);
    @(negedge clk);
    @(negedge clk);
    // pc == 0x108: breakpoint and stop together, breakpoint wins.
    @(negedge clk); stop_req = 1'b1; halt_q.push_back({30'h108, 2'd3}); #1;
    check("stop_brk_freeze", cpu_stat_pc, 0);
    drain_check("stop_brk");

    // Single step with three stalled cycles; breakpoint at current PC is ignored.
    @(negedge clk); step_req = 1'b1; stall = 1'b1; halt_q.push_back({30'h109, 2'd2});
    adv = 0;
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk); step_req = 1'b0; stall = (s < 4); #1;
      adv += int'(cpu_stat_pc);
      check($sformatf("step_s%0d", s), cpu_stat_pc, (s == 4));
    end
    drain_check("step");
    check("step_adv_count", adv, 1);

    // Stop during a step: no advance.
    @(negedge clk); step_req = 1'b1; halt_q.push_back({30'h109, 2'd1});
    @(negedge clk); step_req = 1'b0; stop_req = 1'b1; #1;
    check("step_stop_no_adv", cpu_stat_pc, 0);
    drain_check("step_stop");

    // Reset in the middle of DRAIN.
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    @(negedge clk); stop_req = 1'b1;
    @(negedge clk); stop_req = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    check("reset_in_drain", {cpu_start, cpu_start_adr, cpu_stat_pc, running, halted, halt_pc,
                             halt_cause}, 0);
    @(negedge clk); rst = 1'b0;

    // run_req and step_req together from IDLE: START then STEP.
    @(negedge clk); run_req = 1'b1; step_req = 1'b1; start_adr_in = 30'h200;
    start_q.push_back(30'h200); halt_q.push_back({30'h201, 2'd2});
    @(negedge clk); run_req = 1'b0; step_req = 1'b0; #1;
    check("restart_pulse", cpu_start, 1);
    @(negedge clk); #1;
    check("step_after_start", {cpu_start, cpu_stat_pc}, 2'b01);
    drain_check("idle_step");

    repeat (3) @(negedge clk);
    #3;
    check("start_q_empty", start_q.size(), 0);
    check("halt_q_empty", halt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
